// File: rtl/slicel_cfg_loader_if.sv
// ---------------------------------------------------------------------------
// slicel_cfg_loader_if
//   Word-stream handshake carrying slice bitstream words into the loader.
//
//   Signals:
//     in_valid  producer -> loader   word on in_data is valid
//     in_ready  loader   -> producer loader accepts a word this cycle
//     in_data   producer -> loader   WORD_W-bit config word
//
//   Modports:
//     master  bitstream source (drives in_valid/in_data)
//     slave   loader side       (drives in_ready)
// ---------------------------------------------------------------------------
interface slicel_cfg_loader_if #(
    parameter int WORD_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/slicel_cfg_loader.sv
// ---------------------------------------------------------------------------
// slicel_cfg_loader
//   Streams the slice bitstream in as WORD_W-bit words, assembles them in a
//   shadow register and commits every config field to the slice in a single
//   cycle. Drives the slice cen (1 = configuring, 0 = operating). A new load
//   may be started at any time with a start pulse; no reset is needed.
//
//   Optional feature (macro SLICEL_CFG_CRC_EN):
//     After the data words a check word equal to the XOR of all data words
//     (pad bits included) is expected. A mismatch rejects the load, raises
//     err and keeps the previously committed configuration.
//     With the macro undefined there is no check state and err is 0.
//
//   Ports:
//     cclk                  config clock, rising edge
//     rst_n                 asynchronous active-low reset
//     start                 single-cycle pulse, begins (or restarts) a load
//     in_if                 word handshake (in_valid / in_ready / in_data)
//     luts_config_in        committed LUT config, bitstream [LUT_BITS-1:0]
//     inter_lut_mux_config  committed inter-LUT mux config, next MUX_LVLS bits
//     config_use_cc         committed carry-chain enable, next bit
//     regs_config_in        committed register init values, top field
//     cen                   slice config enable
//     busy                  load in progress
//     done                  valid configuration committed
//     err                   last load rejected (check word mismatch)
//
//   Bitstream word k carries bits [k*WORD_W +: WORD_W]; bits of the last
//   word above CFG_BITS-1 are padding and are discarded.
// ---------------------------------------------------------------------------
module slicel_cfg_loader #(
    parameter int S_XX_BASE = 4,
    parameter int NUM_LUTS  = 4,
    parameter int CFG_SIZE  = 2 * (2 ** S_XX_BASE) + 1,
    parameter int MUX_LVLS  = $clog2(NUM_LUTS),
    parameter int WORD_W    = 8,
    parameter int CFG_BITS  = CFG_SIZE * NUM_LUTS + MUX_LVLS + 1 + 2 * NUM_LUTS,
    parameter int NUM_WORDS = (CFG_BITS + WORD_W - 1) / WORD_W
) (
    input  logic                         cclk,
    input  logic                         rst_n,
    input  logic                         start,
    slicel_cfg_loader_if.slave           in_if,
    output logic [CFG_SIZE*NUM_LUTS-1:0] luts_config_in,
    output logic [MUX_LVLS-1:0]          inter_lut_mux_config,
    output logic                         config_use_cc,
    output logic [2*NUM_LUTS-1:0]        regs_config_in,
    output logic                         cen,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int LUT_BITS = CFG_SIZE * NUM_LUTS;
    localparam int CNT_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int PAD_W    = NUM_WORDS * WORD_W;

`ifdef SLICEL_CFG_CRC_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;
`endif

    state_t                       state;
    state_t                       state_nx;

    logic [CNT_W-1:0]             cnt;
    logic [CNT_W-1:0]             cnt_nx;
    logic [CFG_BITS-1:0]          shadow;
    logic [CFG_BITS-1:0]          shadow_nx;
    logic [CFG_BITS-1:0]          cfg_q;
    logic [CFG_BITS-1:0]          commit_src;
    logic [NUM_WORDS-1:0][WORD_W-1:0] words;

    logic                         ready_int;
    logic                         beat;
    logic                         data_beat;
    logic                         last_data;
    logic                         commit;

`ifdef SLICEL_CFG_CRC_EN
    logic [WORD_W-1:0]            xor_acc;
    logic [WORD_W-1:0]            xor_nx;
    logic                         chk_beat;
    logic                         chk_ok;
`endif

    // -----------------------------------------------------------------------
    // Handshake qualification. start takes priority over a data beat in the
    // same cycle: such a beat is dropped rather than stored.
    // -----------------------------------------------------------------------
    always_comb begin
`ifdef SLICEL_CFG_CRC_EN
        ready_int = (state == S_LOAD) || (state == S_CHK);
`else
        ready_int = (state == S_LOAD);
`endif
        beat      = in_if.in_valid && ready_int && !start;
        data_beat = beat && (state == S_LOAD);
        last_data = data_beat && (cnt == CNT_W'(NUM_WORDS - 1));
    end

`ifdef SLICEL_CFG_CRC_EN
    always_comb begin
        chk_beat = beat && (state == S_CHK);
        chk_ok   = (in_if.in_data == xor_acc);
    end
`endif

    // -----------------------------------------------------------------------
    // Next-state logic.
    // -----------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = S_LOAD;
        end else begin
            case (state)
                S_LOAD: begin
                    if (last_data) begin
`ifdef SLICEL_CFG_CRC_EN
                        state_nx = S_CHK;
`else
                        state_nx = S_DONE;
`endif
                    end
                end
`ifdef SLICEL_CFG_CRC_EN
                S_CHK: begin
                    if (chk_beat) begin
                        state_nx = chk_ok ? S_DONE : S_ERR;
                    end
                end
`endif
                default: begin
                    state_nx = state;
                end
            endcase
        end
    end

    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // -----------------------------------------------------------------------
    // Shadow assembly. The shadow is viewed as whole words (padding included)
    // so the incoming word lands at its slot by index; the pad bits fall off
    // when the view is truncated back to CFG_BITS.
    // -----------------------------------------------------------------------
    always_comb begin
        words = PAD_W'(shadow);
        if (data_beat) begin
            words[cnt] = in_if.in_data;
        end

        shadow_nx = shadow;
        cnt_nx    = cnt;
        if (start) begin
            shadow_nx = '0;
            cnt_nx    = '0;
        end else if (data_beat) begin
            shadow_nx = CFG_BITS'(words);
            cnt_nx    = cnt + CNT_W'(1);
        end
    end

`ifdef SLICEL_CFG_CRC_EN
    always_comb begin
        xor_nx = xor_acc;
        if (start) begin
            xor_nx = '0;
        end else if (data_beat) begin
            xor_nx = xor_acc ^ in_if.in_data;
        end
    end

    // Commit happens on the check-word edge; the shadow is complete by then.
    always_comb begin
        commit     = chk_beat && chk_ok;
        commit_src = shadow;
    end
`else
    // Commit on the last data edge, taking the merged shadow so the slice
    // sees the full configuration in the cycle right after the handshake.
    always_comb begin
        commit     = last_data;
        commit_src = shadow_nx;
    end
`endif

    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            shadow <= '0;
            cfg_q  <= '0;
        end else begin
            cnt    <= cnt_nx;
            shadow <= shadow_nx;
            if (commit) begin
                cfg_q <= commit_src;
            end
        end
    end

`ifdef SLICEL_CFG_CRC_EN
    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            xor_acc <= '0;
        end else begin
            xor_acc <= xor_nx;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Outputs. Status flags decode the registered state; config fields are
    // fixed slices of the committed bitstream.
    // -----------------------------------------------------------------------
    assign in_if.in_ready       = ready_int;
    assign busy                 = ready_int;
    assign done                 = (state == S_DONE);
    assign cen                  = (state != S_DONE);
`ifdef SLICEL_CFG_CRC_EN
    assign err                  = (state == S_ERR);
`else
    assign err                  = 1'b0;
`endif

    assign luts_config_in       = cfg_q[LUT_BITS-1:0];
    assign inter_lut_mux_config = cfg_q[LUT_BITS +: MUX_LVLS];
    assign config_use_cc        = cfg_q[LUT_BITS + MUX_LVLS];
    assign regs_config_in       = cfg_q[CFG_BITS-1 -: 2*NUM_LUTS];

endmodule

// File: tb/tb_slicel_cfg_loader.sv
module tb_slicel_cfg_loader;

    localparam int S_XX_BASE = 4;
    localparam int NUM_LUTS  = 4;
    localparam int WORD_W    = 8;
    localparam int CFG_SIZE  = 2 * (2 ** S_XX_BASE) + 1;
    localparam int LUT_W     = CFG_SIZE * NUM_LUTS;
    localparam int MUX_W     = $clog2(NUM_LUTS);
    localparam int REG_W     = 2 * NUM_LUTS;
    localparam int CFG_BITS  = LUT_W + MUX_W + 1 + REG_W;
    localparam int NW        = (CFG_BITS + WORD_W - 1) / WORD_W;

    logic cclk  = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;

    logic [LUT_W-1:0] luts_config_in;
    logic [MUX_W-1:0] inter_lut_mux_config;
    logic             config_use_cc;
    logic [REG_W-1:0] regs_config_in;
    logic             cen, busy, done, err;

    slicel_cfg_loader_if #(.WORD_W(WORD_W)) in_if ();

    slicel_cfg_loader #(
        .S_XX_BASE (S_XX_BASE),
        .NUM_LUTS  (NUM_LUTS),
        .WORD_W    (WORD_W)
    ) dut (
        .cclk                 (cclk),
        .rst_n                (rst_n),
        .start                (start),
        .in_if                (in_if),
        .luts_config_in       (luts_config_in),
        .inter_lut_mux_config (inter_lut_mux_config),
        .config_use_cc        (config_use_cc),
        .regs_config_in       (regs_config_in),
        .cen                  (cen),
        .busy                 (busy),
        .done                 (done),
        .err                  (err)
    );

    always #5 cclk = ~cclk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit                m_loading;
    bit                m_done;
    bit                m_err;
    int                m_n;
    logic [7:0]        m_words [NW];
    logic [7:0]        m_xor;
    logic [CFG_BITS-1:0] m_cfg;

    logic [7:0]        w [NW];     // stimulus words for the next load

    function automatic void model_reset();
        m_loading = 0; m_done = 0; m_err = 0; m_n = 0; m_xor = '0; m_cfg = '0;
    endfunction

    function automatic void model_commit();
        for (int k = 0; k < NW; k++)
            for (int b = 0; b < WORD_W; b++)
                if (k * WORD_W + b < CFG_BITS) m_cfg[k * WORD_W + b] = m_words[k][b];
        m_done = 1;
    endfunction

    function automatic void model_edge(input bit st, input bit v, input logic [7:0] d);
        if (st) begin
            m_loading = 1; m_done = 0; m_err = 0; m_n = 0; m_xor = '0;
            for (int k = 0; k < NW; k++) m_words[k] = '0;
        end else if (m_loading && v) begin
            if (m_n < NW) begin
                m_words[m_n] = d;
                m_xor = m_xor ^ d;
                m_n++;
`ifndef SLICEL_CFG_CRC_EN
                if (m_n == NW) begin
                    m_loading = 0;
                    model_commit();
                end
`endif
            end else begin
                m_loading = 0;
                if (d == m_xor) model_commit();
                else m_err = 1;
            end
        end
    endfunction

    task automatic compare_all(input string ctx);
        check({ctx, ".luts"},  luts_config_in,       m_cfg[LUT_W-1:0]);
        check({ctx, ".mux"},   inter_lut_mux_config, m_cfg[LUT_W +: MUX_W]);
        check({ctx, ".cc"},    config_use_cc,        m_cfg[LUT_W + MUX_W]);
        check({ctx, ".regs"},  regs_config_in,       m_cfg[CFG_BITS-1 -: REG_W]);
        check({ctx, ".ready"}, in_if.in_ready,       m_loading);
        check({ctx, ".busy"},  busy,                 m_loading);
        check({ctx, ".done"},  done,                 m_done);
        check({ctx, ".cen"},   cen,                  !m_done);
        check({ctx, ".err"},   err,                  m_err);
    endtask

    // One clock: drive inputs, advance the model, sample 1 ns after the edge.
    task automatic cyc(input string ctx, input bit st, input bit v, input logic [7:0] d);
        start = st; in_if.in_valid = v; in_if.in_data = d;
        model_edge(st, v, d);
        @(posedge cclk);
        #1;
        compare_all(ctx);
    endtask

    // gap_mode: 0 back-to-back, 1 every other cycle idle, 2 random idles.
    // stop_after < NW leaves the load unfinished; bad_chk corrupts the check word.
    task automatic load_words(input string ctx, input int gap_mode, input int stop_after, input bit bad_chk);
        int sent = 0;
        int target;
        logic [7:0] chk = '0;
        bit v;
        for (int k = 0; k < NW; k++) chk = chk ^ w[k];
        if (bad_chk) chk = chk ^ 8'h01;
        target = stop_after;
`ifdef SLICEL_CFG_CRC_EN
        if (stop_after >= NW) target = NW + 1;
`endif
        for (int c = 0; c < 1000 && sent < target; c++) begin
            case (gap_mode)
                1:       v = (c % 2) == 0;
                2:       v = $urandom_range(0, 99) >= 30;
                default: v = 1'b1;
            endcase
            cyc(ctx, 1'b0, v, (sent < NW) ? w[sent] : chk);
            if (v) sent++;
        end
        if (sent < target) check({ctx, ".budget"}, sent, target);
        in_if.in_valid = 1'b0;
    endtask

    task automatic async_reset(input string ctx);
        start = 1'b0; in_if.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare_all(ctx);
        #3 rst_n = 1'b1;
        @(posedge cclk);
        #1 compare_all({ctx, "_rel"});
    endtask

    initial begin
        in_if.in_valid = 1'b0;
        in_if.in_data  = '0;
        model_reset();
        #2 compare_all("rst");
        @(posedge cclk);
        #3 rst_n = 1'b1;
        @(posedge cclk);
        #1 compare_all("rst_rel");

        // Incrementing data, back to back.
        for (int k = 0; k < NW; k++) w[k] = 8'(k);
        cyc("inc_start", 1'b1, 1'b0, 8'h00);
        load_words("inc", 0, NW, 1'b0);
        check("inc_regs_const", regs_config_in, 8'b00100010);
        check("inc_done_const", done, 1'b1);
        cyc("inc_extra_word", 1'b0, 1'b1, 8'h5A);
        cyc("inc_hold", 1'b0, 1'b0, 8'h00);

        // Same data under backpressure.
        cyc("bp_start", 1'b1, 1'b0, 8'h00);
        load_words("bp", 1, NW, 1'b0);

        // Restart after 5 words, then all-ones load.
        for (int k = 0; k < NW; k++) w[k] = 8'($urandom);
        cyc("rs_start", 1'b1, 1'b0, 8'h00);
        load_words("rs_part", 0, 5, 1'b0);
        for (int k = 0; k < NW; k++) w[k] = 8'hFF;
        cyc("rs_restart", 1'b1, 1'b0, 8'h00);
        load_words("rs_full", 0, NW, 1'b0);
        check("ones_luts", luts_config_in, {LUT_W{1'b1}});
        check("ones_regs", regs_config_in, {REG_W{1'b1}});

        // Reset in the middle of a load, then a full load.
        for (int k = 0; k < NW; k++) w[k] = 8'($urandom);
        cyc("rm_start", 1'b1, 1'b0, 8'h00);
        load_words("rm_part", 0, 10, 1'b0);
        async_reset("rm_reset");
        cyc("rm_start2", 1'b1, 1'b0, 8'h00);
        load_words("rm_full", 2, NW, 1'b0);
        async_reset("done_reset");

        // start colliding with the final data beat: restart wins, no commit.
        for (int k = 0; k < NW; k++) w[k] = 8'($urandom);
        cyc("col_start", 1'b1, 1'b0, 8'h00);
        load_words("col_part", 0, NW - 1, 1'b0);
        cyc("col_hit", 1'b1, 1'b1, w[NW-1]);
        load_words("col_full", 0, NW, 1'b0);

        // Randomized loads with occasional restarts that collide with a beat.
        for (int it = 0; it < 12; it++) begin
            for (int k = 0; k < NW; k++) w[k] = 8'($urandom);
            cyc("rnd_start", 1'b1, 1'b0, 8'h00);
            if ($urandom_range(0, 3) == 0) begin
                load_words("rnd_part", 2, $urandom_range(1, NW - 1), 1'b0);
                cyc("rnd_restart", 1'b1, 1'b1, 8'($urandom));
            end
            load_words("rnd", 2, NW, 1'b0);
            for (int i = 0; i < 2; i++) cyc("rnd_idle", 1'b0, 1'($urandom), 8'($urandom));
        end

`ifdef SLICEL_CFG_CRC_EN
        for (int k = 0; k < NW; k++) w[k] = 8'hA5;
        cyc("crc_ok_start", 1'b1, 1'b0, 8'h00);
        load_words("crc_ok", 0, NW, 1'b0);
        check("crc_ok_err", err, 1'b0);
        check("crc_ok_done", done, 1'b1);
        cyc("crc_bad_start", 1'b1, 1'b0, 8'h00);
        load_words("crc_bad", 0, NW, 1'b1);
        check("crc_bad_err", err, 1'b1);
        check("crc_bad_cen", cen, 1'b1);
        cyc("crc_err_hold", 1'b0, 1'b1, 8'h00);
        for (int k = 0; k < NW; k++) w[k] = 8'($urandom);
        cyc("crc_recover_start", 1'b1, 1'b0, 8'h00);
        load_words("crc_recover", 2, NW, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
